// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states, opcode
// and funct fields, ALU control encodings and the ALU operation classes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_ALUEX  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BREX   = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JEX    = 4'd11,
        S_JALEX  = 4'd12,
        S_ERR    = 4'd13
    } state_t;

    // Operation class handed to the ALU decoder; NONE yields alucontrol=000.
    typedef enum logic [2:0] {
        ALUOP_NONE  = 3'd0,
        ALUOP_ADD   = 3'd1,
        ALUOP_SUB   = 3'd2,
        ALUOP_AND   = 3'd3,
        ALUOP_OR    = 3'd4,
        ALUOP_SLT   = 3'd5,
        ALUOP_FUNCT = 3'd6
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // States that wait on mem_ready and are subject to the access timeout.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU control decode from the operation class chosen by the
// controller and, for R-type instructions, the funct field.
module mc_aludec
    import mips_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       bad_funct
);

    always_comb begin
        alucontrol = ALU_AND;
        bad_funct  = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_AND: alucontrol = ALU_AND;
            ALUOP_OR:  alucontrol = ALU_OR;
            ALUOP_SLT: alucontrol = ALU_SLT;
            ALUOP_FUNCT: begin
                // Unknown funct still executes as add but is flagged.
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default: begin
                        alucontrol = ALU_ADD;
                        bad_funct  = 1'b1;
                    end
                endcase
            end
            default: alucontrol = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_controller_hs.sv
// Multicycle MIPS control FSM with a handshaked memory port: every memory
// access waits for mem_ready and gives up into a sticky ERR state on timeout.
module mc_controller_hs
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter bit EXT_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       immext,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [2:0] alucontrol,
    output logic       err,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     cur_state, next_state;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic [2:0] aluop;
    logic       bad_funct;
    logic       timeout;

    logic is_lw, is_sw, is_rtype, is_beq, is_bne, is_addi;
    logic is_andi, is_ori, is_slti, is_j, is_jal, op_legal;

    // Extension opcodes decode as nothing when EXT_EN is off, so they fall
    // through to the illegal path in DECODE.
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_rtype = (op == OP_RTYPE);
    assign is_beq   = (op == OP_BEQ);
    assign is_addi  = (op == OP_ADDI);
    assign is_j     = (op == OP_J);
    assign is_bne   = EXT_EN && (op == OP_BNE);
    assign is_andi  = EXT_EN && (op == OP_ANDI);
    assign is_ori   = EXT_EN && (op == OP_ORI);
    assign is_slti  = EXT_EN && (op == OP_SLTI);
    assign is_jal   = EXT_EN && (op == OP_JAL);

    assign op_legal = is_lw | is_sw | is_rtype | is_beq | is_bne | is_addi |
                      is_andi | is_ori | is_slti | is_j | is_jal;

    // mem_ready wins over an expiring wait budget in the same cycle.
    assign timeout = !mem_ready && (wait_cnt == WAIT_LAST);

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol),
        .bad_funct  (bad_funct)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_FETCH;
            wait_cnt  <= 8'd0;
        end else begin
            cur_state <= next_state;
            wait_cnt  <= wait_cnt_next;
        end
    end

    always_comb begin
        next_state    = cur_state;
        wait_cnt_next = 8'd0;
        if (is_wait_state(cur_state)) begin
            if (mem_ready) begin
                case (cur_state)
                    S_FETCH: next_state = S_DECODE;
                    S_MEMRD: next_state = S_MEMWB;
                    default: next_state = S_FETCH;
                endcase
            end else if (timeout) begin
                next_state = S_ERR;
            end else begin
                wait_cnt_next = wait_cnt + 8'd1;
            end
        end else begin
            case (cur_state)
                S_DECODE: begin
                    if (is_lw || is_sw)                           next_state = S_MEMADR;
                    else if (is_rtype)                            next_state = S_ALUEX;
                    else if (is_beq || is_bne)                    next_state = S_BREX;
                    else if (is_addi || is_andi || is_ori || is_slti) next_state = S_IMMEX;
                    else if (is_j)                                next_state = S_JEX;
                    else if (is_jal)                              next_state = S_JALEX;
                    else                                          next_state = S_FETCH;
                end
                S_MEMADR: next_state = is_sw ? S_MEMWR : S_MEMRD;
                S_ALUEX:  next_state = S_ALUWB;
                S_IMMEX:  next_state = S_IMMWB;
                S_ERR:    next_state = S_ERR;
                default:  next_state = S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        memwrite = 1'b0;
        pcwrite  = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        immext   = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        regdst   = 2'b00;
        memtoreg = 2'b00;
        aluop    = ALUOP_NONE;
        err      = 1'b0;
        illegal  = 1'b0;
        state    = cur_state;
        case (cur_state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                aluop   = ALUOP_ADD;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                aluop   = ALUOP_ADD;
                illegal = !op_legal;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 2'b01;
            end
            S_ALUEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                illegal = bad_funct;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 2'b01;
            end
            S_BREX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                pcwrite = is_beq ? zero : !zero;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                immext  = is_andi || is_ori;
                if (is_andi)      aluop = ALUOP_AND;
                else if (is_ori)  aluop = ALUOP_OR;
                else if (is_slti) aluop = ALUOP_SLT;
                else              aluop = ALUOP_ADD;
            end
            S_IMMWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            S_JALEX: begin
                pcsrc    = 2'b10;
                pcwrite  = 1'b1;
                regwrite = 1'b1;
                regdst   = 2'b10;
                memtoreg = 2'b10;
            end
            S_ERR:   err = 1'b1;
            default: err = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Bench for mc_controller_hs: two instances (full decode/15-cycle budget and
// reduced decode/4-cycle budget) checked against an instruction-level model.
module tb_mc_controller_hs;
    import mips_pkg::*;

    localparam logic [5:0] I_RT   = 6'h00;
    localparam logic [5:0] I_J    = 6'h02;
    localparam logic [5:0] I_JAL  = 6'h03;
    localparam logic [5:0] I_BEQ  = 6'h04;
    localparam logic [5:0] I_BNE  = 6'h05;
    localparam logic [5:0] I_ADDI = 6'h08;
    localparam logic [5:0] I_SLTI = 6'h0a;
    localparam logic [5:0] I_ANDI = 6'h0c;
    localparam logic [5:0] I_ORI  = 6'h0d;
    localparam logic [5:0] I_LW   = 6'h23;
    localparam logic [5:0] I_SW   = 6'h2b;
    localparam int MAX_A = 15;
    localparam int MAX_B = 4;
    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_BNE = 4, C_ADDI = 5;
    localparam int C_ANDI = 6, C_ORI = 7, C_SLTI = 8, C_J = 9, C_JAL = 10, C_BAD = 11;
    localparam logic [5:0] OPTAB [11] = '{I_RT, I_LW, I_SW, I_BEQ, I_BNE, I_ADDI,
                                          I_ANDI, I_ORI, I_SLTI, I_J, I_JAL};
    localparam logic [5:0] FTAB [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [5:0] op_a = '0, funct_a = '0, op_b = '0, funct_b = '0;
    logic zero_a = 1'b0, rdy_a = 1'b0, zero_b = 1'b0, rdy_b = 1'b0;

    logic a_mem_req, a_memwrite, a_pcwrite, a_irwrite, a_regwrite, a_iord;
    logic a_alusrca, a_immext, a_err, a_illegal;
    logic [1:0] a_alusrcb, a_pcsrc, a_regdst, a_memtoreg;
    logic [2:0] a_alucontrol;
    logic [3:0] a_state;
    logic b_mem_req, b_memwrite, b_pcwrite, b_irwrite, b_regwrite, b_iord;
    logic b_alusrca, b_immext, b_err, b_illegal;
    logic [1:0] b_alusrcb, b_pcsrc, b_regdst, b_memtoreg;
    logic [2:0] b_alucontrol;
    logic [3:0] b_state;

    int checks = 0;
    int errors = 0;
    state_t ms_a = S_FETCH, ms_b = S_FETCH;
    int mw_a = 0, mw_b = 0;
    logic [24:0] exp_a, act_a, exp_b, act_b;

    always #5 clk = ~clk;

    mc_controller_hs #(.MEM_WAIT_MAX(MAX_A), .EXT_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .op(op_a), .funct(funct_a), .zero(zero_a),
        .mem_ready(rdy_a), .mem_req(a_mem_req), .memwrite(a_memwrite),
        .pcwrite(a_pcwrite), .irwrite(a_irwrite), .regwrite(a_regwrite),
        .iord(a_iord), .alusrca(a_alusrca), .immext(a_immext),
        .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .regdst(a_regdst),
        .memtoreg(a_memtoreg), .alucontrol(a_alucontrol), .err(a_err),
        .illegal(a_illegal), .state(a_state)
    );

    mc_controller_hs #(.MEM_WAIT_MAX(MAX_B), .EXT_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .op(op_b), .funct(funct_b), .zero(zero_b),
        .mem_ready(rdy_b), .mem_req(b_mem_req), .memwrite(b_memwrite),
        .pcwrite(b_pcwrite), .irwrite(b_irwrite), .regwrite(b_regwrite),
        .iord(b_iord), .alusrca(b_alusrca), .immext(b_immext),
        .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .regdst(b_regdst),
        .memtoreg(b_memtoreg), .alucontrol(b_alucontrol), .err(b_err),
        .illegal(b_illegal), .state(b_state)
    );

    function automatic int iclass(input logic [5:0] op, input bit ext);
        case (op)
            I_LW:    return C_LW;
            I_SW:    return C_SW;
            I_RT:    return C_R;
            I_BEQ:   return C_BEQ;
            I_ADDI:  return C_ADDI;
            I_J:     return C_J;
            I_BNE:   return ext ? C_BNE  : C_BAD;
            I_ANDI:  return ext ? C_ANDI : C_BAD;
            I_ORI:   return ext ? C_ORI  : C_BAD;
            I_SLTI:  return ext ? C_SLTI : C_BAD;
            I_JAL:   return ext ? C_JAL  : C_BAD;
            default: return C_BAD;
        endcase
    endfunction

    // Expected output vector, same field order as the packed DUT outputs.
    function automatic logic [24:0] model_out(input state_t s, input bit ext,
            input logic [5:0] op, input logic [5:0] funct, input logic zero, input logic rdy);
        logic mreq, mwr, pcw, irw, rw, io, asa, imx, er, ill;
        logic [1:0] asb, pcs, rd, mtr;
        logic [2:0] alu;
        int c;
        {mreq, mwr, pcw, irw, rw, io, asa, imx, er, ill} = '0;
        {asb, pcs, rd, mtr} = '0;
        alu = 3'b000;
        c = iclass(op, ext);
        case (s)
            S_FETCH:  begin mreq = 1; asb = 2'b01; alu = 3'b010; pcw = rdy; irw = rdy; end
            S_DECODE: begin asb = 2'b11; alu = 3'b010; ill = (c == C_BAD); end
            S_MEMADR: begin asa = 1; asb = 2'b10; alu = 3'b010; end
            S_MEMRD:  begin mreq = 1; io = 1; end
            S_MEMWR:  begin mreq = 1; io = 1; mwr = 1; end
            S_MEMWB:  begin rw = 1; mtr = 2'b01; end
            S_ALUEX: begin
                asa = 1;
                case (funct)
                    6'h20: alu = 3'b010;
                    6'h22: alu = 3'b110;
                    6'h24: alu = 3'b000;
                    6'h25: alu = 3'b001;
                    6'h2a: alu = 3'b111;
                    default: begin alu = 3'b010; ill = 1; end
                endcase
            end
            S_ALUWB:  begin rw = 1; rd = 2'b01; end
            S_BREX:   begin asa = 1; alu = 3'b110; pcs = 2'b01; pcw = (c == C_BEQ) ? zero : !zero; end
            S_IMMEX: begin
                asa = 1; asb = 2'b10;
                case (c)
                    C_ANDI:  begin alu = 3'b000; imx = 1; end
                    C_ORI:   begin alu = 3'b001; imx = 1; end
                    C_SLTI:  alu = 3'b111;
                    default: alu = 3'b010;
                endcase
            end
            S_IMMWB:  rw = 1;
            S_JEX:    begin pcs = 2'b10; pcw = 1; end
            S_JALEX:  begin pcs = 2'b10; pcw = 1; rw = 1; rd = 2'b10; mtr = 2'b10; end
            S_ERR:    er = 1;
            default:  er = 0;
        endcase
        return {s, mreq, mwr, pcw, irw, rw, io, asa, imx, asb, pcs, rd, mtr, alu, er, ill};
    endfunction

    function automatic void model_next(input state_t s, input int w, input bit ext, input int maxw,
            input logic [5:0] op, input logic rdy, output state_t ns, output int nw);
        int c;
        c = iclass(op, ext);
        ns = S_FETCH;
        nw = 0;
        case (s)
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (rdy) ns = (s == S_FETCH) ? S_DECODE : (s == S_MEMRD) ? S_MEMWB : S_FETCH;
                else if (w + 1 >= maxw) ns = S_ERR;
                else begin ns = s; nw = w + 1; end
            end
            S_DECODE: begin
                case (c)
                    C_LW, C_SW:                    ns = S_MEMADR;
                    C_R:                           ns = S_ALUEX;
                    C_BEQ, C_BNE:                  ns = S_BREX;
                    C_ADDI, C_ANDI, C_ORI, C_SLTI: ns = S_IMMEX;
                    C_J:                           ns = S_JEX;
                    C_JAL:                         ns = S_JALEX;
                    default:                       ns = S_FETCH;
                endcase
            end
            S_MEMADR: ns = (c == C_SW) ? S_MEMWR : S_MEMRD;
            S_ALUEX:  ns = S_ALUWB;
            S_IMMEX:  ns = S_IMMWB;
            S_ERR:    ns = S_ERR;
            default:  ns = S_FETCH;
        endcase
    endfunction

    task automatic step(input logic [5:0] oa, input logic [5:0] fa, input logic za, input logic ra,
                        input logic [5:0] ob, input logic [5:0] fb, input logic zb, input logic rb);
        state_t n;
        int w;
        @(negedge clk);
        op_a = oa; funct_a = fa; zero_a = za; rdy_a = ra;
        op_b = ob; funct_b = fb; zero_b = zb; rdy_b = rb;
        #1;
        exp_a = model_out(ms_a, 1'b1, oa, fa, za, ra);
        exp_b = model_out(ms_b, 1'b0, ob, fb, zb, rb);
        act_a = {a_state, a_mem_req, a_memwrite, a_pcwrite, a_irwrite, a_regwrite, a_iord,
                 a_alusrca, a_immext, a_alusrcb, a_pcsrc, a_regdst, a_memtoreg, a_alucontrol,
                 a_err, a_illegal};
        act_b = {b_state, b_mem_req, b_memwrite, b_pcwrite, b_irwrite, b_regwrite, b_iord,
                 b_alusrca, b_immext, b_alusrcb, b_pcsrc, b_regdst, b_memtoreg, b_alucontrol,
                 b_err, b_illegal};
        model_next(ms_a, mw_a, 1'b1, MAX_A, oa, ra, n, w); ms_a = n; mw_a = w;
        model_next(ms_b, mw_b, 1'b0, MAX_B, ob, rb, n, w); ms_b = n; mw_b = w;
    endtask

    task automatic step2(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
        step(o, f, z, r, o, f, z, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        ms_a = S_FETCH; ms_b = S_FETCH; mw_a = 0; mw_b = 0;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (a_state !== S_FETCH) begin errors++; $display("[TB] FAIL reset_state_a: got %0d expected %0d", a_state, S_FETCH); end
        checks++; if (a_mem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_mem_req_a: got %b expected 1", a_mem_req); end
        checks++; if (a_err !== 1'b0 || a_illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_ill_a: got %b%b expected 00", a_err, a_illegal); end
        checks++; if (b_state !== S_FETCH) begin errors++; $display("[TB] FAIL reset_state_b: got %0d expected %0d", b_state, S_FETCH); end
        @(posedge clk);
        #2 reset = 1'b1;
        step2(I_LW, 6'h20, 1'b0, 1'b1);
        checks++; if (act_a !== exp_a) begin errors++; $display("[TB] FAIL reset_first_fetch_a: got %h expected %h", act_a, exp_a); end
        checks++; if (act_b !== exp_b) begin errors++; $display("[TB] FAIL reset_first_fetch_b: got %h expected %h", act_b, exp_b); end
        checks++; if (a_irwrite !== 1'b1 || a_pcwrite !== 1'b1) begin errors++; $display("[TB] FAIL reset_first_irwrite: got %b%b expected 11", a_irwrite, a_pcwrite); end
    endtask

    task automatic test_lw_wait();
        logic   rdyseq [10];
        state_t sseq [10];
        rdyseq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        sseq   = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR,
                   S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step2(I_LW, 6'h20, 1'b0, rdyseq[i]);
            checks++; if (act_a !== exp_a) begin errors++; $display("[TB] FAIL lw_model_a[%0d]: got %h expected %h", i, act_a, exp_a); end
            checks++; if (act_b !== exp_b) begin errors++; $display("[TB] FAIL lw_model_b[%0d]: got %h expected %h", i, act_b, exp_b); end
            checks++; if (a_state !== sseq[i]) begin errors++; $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, a_state, sseq[i]); end
            checks++; if (a_regwrite !== (i == 9) || a_memtoreg !== ((i == 9) ? 2'b01 : 2'b00)) begin
                errors++; $display("[TB] FAIL lw_writeback[%0d]: got %b/%b expected %b", i, a_regwrite, a_memtoreg, (i == 9));
            end
        end
    endtask

    task automatic test_branch();
        for (int zz = 0; zz < 2; zz++) begin
            logic zv;
            zv = (zz == 1);
            do_reset();
            for (int i = 0; i < 4; i++) begin
                step2(I_BNE, 6'h20, zv, (i == 0));
                checks++; if (act_a !== exp_a) begin errors++; $display("[TB] FAIL bne_model_a[%0d]: got %h expected %h", i, act_a, exp_a); end
                checks++; if (act_b !== exp_b) begin errors++; $display("[TB] FAIL bne_model_b[%0d]: got %h expected %h", i, act_b, exp_b); end
                if (i == 1) begin
                    checks++; if (a_illegal !== 1'b0 || b_illegal !== 1'b1) begin errors++; $display("[TB] FAIL bne_illegal: got a=%b b=%b expected a=0 b=1", a_illegal, b_illegal); end
                end
                if (i == 2) begin
                    checks++; if (a_state !== S_BREX || a_pcwrite !== !zv || a_pcsrc !== 2'b01) begin
                        errors++; $display("[TB] FAIL bne_brex z=%b: got state=%0d pcwrite=%b pcsrc=%b expected %0d %b 01", zv, a_state, a_pcwrite, a_pcsrc, S_BREX, !zv);
                    end
                end
            end
        end
    endtask

    task automatic test_jal();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step2(I_JAL, 6'h20, 1'b0, (i == 0));
            checks++; if (act_a !== exp_a) begin errors++; $display("[TB] FAIL jal_model_a[%0d]: got %h expected %h", i, act_a, exp_a); end
            checks++; if (act_b !== exp_b) begin errors++; $display("[TB] FAIL jal_model_b[%0d]: got %h expected %h", i, act_b, exp_b); end
            if (i == 1) begin
                checks++; if (b_illegal !== 1'b1 || a_illegal !== 1'b0) begin errors++; $display("[TB] FAIL jal_illegal: got a=%b b=%b expected a=0 b=1", a_illegal, b_illegal); end
            end
            if (i == 2) begin
                checks++; if (a_state !== S_JALEX || a_regdst !== 2'b10 || a_memtoreg !== 2'b10 || a_regwrite !== 1'b1 || a_pcwrite !== 1'b1) begin
                    errors++; $display("[TB] FAIL jal_jalex: got st=%0d rd=%b mtr=%b rw=%b pcw=%b expected %0d 10 10 1 1", a_state, a_regdst, a_memtoreg, a_regwrite, a_pcwrite, S_JALEX);
                end
                checks++; if (b_state !== S_FETCH || b_illegal !== 1'b0) begin errors++; $display("[TB] FAIL jal_b_refetch: got st=%0d ill=%b expected %0d 0", b_state, b_illegal, S_FETCH); end
            end
        end
    endtask

    task automatic test_timeout();
        logic r;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            r = (i == 0) ? 1'b1 : (i < 7) ? 1'b0 : 1'($urandom_range(0, 1));
            step2(I_SW, 6'h20, 1'b0, r);
            checks++; if (act_a !== exp_a) begin errors++; $display("[TB] FAIL tmo_model_a[%0d]: got %h expected %h", i, act_a, exp_a); end
            checks++; if (act_b !== exp_b) begin errors++; $display("[TB] FAIL tmo_model_b[%0d]: got %h expected %h", i, act_b, exp_b); end
            if (i >= 3 && i < 7) begin
                checks++; if (b_state !== S_MEMWR || b_memwrite !== 1'b1) begin errors++; $display("[TB] FAIL tmo_wait[%0d]: got st=%0d mw=%b expected %0d 1", i, b_state, b_memwrite, S_MEMWR); end
            end
            if (i >= 7) begin
                checks++; if (b_state !== S_ERR || b_err !== 1'b1 || b_mem_req !== 1'b0) begin
                    errors++; $display("[TB] FAIL tmo_err[%0d]: got st=%0d err=%b req=%b expected %0d 1 0", i, b_state, b_err, b_mem_req, S_ERR);
                end
            end
        end
    endtask

    task automatic test_reset_mid_memrd();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step2(I_LW, 6'h20, 1'b0, (i == 0));
            checks++; if (act_a !== exp_a) begin errors++; $display("[TB] FAIL rmid_model_a[%0d]: got %h expected %h", i, act_a, exp_a); end
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (a_state !== S_FETCH || a_mem_req !== 1'b1 || a_err !== 1'b0 || a_regwrite !== 1'b0 || a_iord !== 1'b0) begin
            errors++; $display("[TB] FAIL rmid_abort: got st=%0d req=%b err=%b rw=%b iord=%b expected %0d 1 0 0 0", a_state, a_mem_req, a_err, a_regwrite, a_iord, S_FETCH);
        end
        checks++; if (b_state !== S_FETCH || b_mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rmid_abort_b: got st=%0d req=%b expected %0d 1", b_state, b_mem_req, S_FETCH); end
        ms_a = S_FETCH; ms_b = S_FETCH; mw_a = 0; mw_b = 0;
        @(posedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step2(I_LW, 6'h20, 1'b0, 1'b1);
            checks++; if (act_a !== exp_a) begin errors++; $display("[TB] FAIL rmid_resume_a[%0d]: got %h expected %h", i, act_a, exp_a); end
            checks++; if (act_b !== exp_b) begin errors++; $display("[TB] FAIL rmid_resume_b[%0d]: got %h expected %h", i, act_b, exp_b); end
        end
    endtask

    task automatic test_random();
        logic [5:0] oa, fa, ob, fb;
        int k;
        oa = I_LW; fa = 6'h20; ob = I_LW; fb = 6'h20;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ((ms_b == S_ERR || ms_a == S_ERR) && $urandom_range(0, 5) == 0) do_reset();
            if (ms_a == S_FETCH) begin
                k = $urandom_range(0, 11);
                oa = (k == 11) ? 6'($urandom) : OPTAB[k];
                k = $urandom_range(0, 5);
                fa = (k == 5) ? 6'($urandom) : FTAB[k];
            end
            if (ms_b == S_FETCH) begin
                k = $urandom_range(0, 11);
                ob = (k == 11) ? 6'($urandom) : OPTAB[k];
                k = $urandom_range(0, 5);
                fb = (k == 5) ? 6'($urandom) : FTAB[k];
            end
            step(oa, fa, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6),
                 ob, fb, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
            checks++; if (act_a !== exp_a) begin errors++; $display("[TB] FAIL rand_a[%0d] op=%h: got %h expected %h", i, oa, act_a, exp_a); end
            checks++; if (act_b !== exp_b) begin errors++; $display("[TB] FAIL rand_b[%0d] op=%h: got %h expected %h", i, ob, act_b, exp_b); end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_lw_wait();
        test_branch();
        test_jal();
        test_timeout();
        test_reset_mid_memrd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
